regression_inverse: RTL and testbench

Sequential inverse of the fixed linear regression datapath y = A·x + B. Given a 32-bit target y, it recovers the 16-bit input x = floor((y − B) / A) and the remainder using a 16-step restoring divider. It sits downstream of the regression output and feeds recovered feature values back to the host-side checker. Valid/ready handshakes are used on both sides.

---
 rtl/regression_inverse_if.sv | 37 +++
 rtl/regression_inverse.sv | 129 ++++++++++++
 tb/tb_regression_inverse.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/regression_inverse_if.sv
// Handshake bundle for regression_inverse: input y with valid/ready,
// result x/rem/flags with valid/ready. slave = divider, master = host.
interface regression_inverse_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
  logic [15:0] rem;
  logic        underflow;
  logic        overflow;

  modport slave (
    input  in_valid,
    input  y,
    input  out_ready,
    output in_ready,
    output out_valid,
    output x,
    output rem,
    output underflow,
    output overflow
  );

  modport master (
    output in_valid,
    output y,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  x,
    input  rem,
    input  underflow,
    input  overflow
  );
endinterface

// File: rtl/regression_inverse.sv
// Sequential inverse of y = A*x + B: x = floor((y-B)/A), rem = (y-B)%A.
// Ports: clk, rst (async, active-high), bus (regression_inverse_if.slave).
module regression_inverse #(
  parameter logic [15:0] A = 16'd3,
  parameter logic [31:0] B = 32'd7
) (
  input  logic                  clk,
  input  logic                  rst,
  regression_inverse_if.slave   bus
);

  if (A == 16'd0) begin : g_a_zero
    $error("regression_inverse: A must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIVIDE,
    DONE
  } state_t;

  state_t      state_q;
  logic [31:0] y_q;
  logic [15:0] dvd_q;
  logic [15:0] part_q;
  logic [3:0]  cnt_q;
  logic [15:0] x_q;
  logic [15:0] rem_q;
  logic        uf_q;
  logic        of_q;
  logic        ov_q;

  logic [32:0] d_d;
  logic        uf_d;
  logic        of_d;
  logic [16:0] t_d;
  logic        ge_d;
  logic [15:0] part_d;
  logic [15:0] quo_d;

  // Borrow out of the 33-bit subtract flags y < B.
  assign d_d  = {1'b0, y_q} - {1'b0, B};
  assign uf_d = d_d[32];
  assign of_d = {16'd0, d_d[31:0]} >= {16'd0, A, 16'd0};

  // One restoring step. The subtract result is < A, so the low
  // 16 bits carry the full value.
  assign t_d    = {part_q, dvd_q[15]};
  assign ge_d   = t_d >= {1'b0, A};
  assign part_d = ge_d ? (t_d[15:0] - A) : t_d[15:0];

  // Dividend bits shift out the top while quotient bits enter below.
  assign quo_d = {dvd_q[14:0], ge_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      dvd_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      rem_q   <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            y_q     <= bus.y;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (uf_d) begin
            x_q     <= '0;
            rem_q   <= '0;
            uf_q    <= 1'b1;
            of_q    <= 1'b0;
            ov_q    <= 1'b1;
            state_q <= DONE;
          end else if (of_d) begin
            x_q     <= 16'hFFFF;
            rem_q   <= '0;
            uf_q    <= 1'b0;
            of_q    <= 1'b1;
            ov_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            part_q  <= d_d[31:16];
            dvd_q   <= d_d[15:0];
            cnt_q   <= '0;
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          part_q <= part_d;
          dvd_q  <= quo_d;
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            x_q     <= quo_d;
            rem_q   <= part_d;
            uf_q    <= 1'b0;
            of_q    <= 1'b0;
            ov_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.x         = x_q;
  assign bus.rem       = rem_q;
  assign bus.underflow = uf_q;
  assign bus.overflow  = of_q;

endmodule

// File: tb/tb_regression_inverse.sv
// Scoreboard bench for regression_inverse with A=3, B=7.
// Expected results come from a 64-bit reference model.
module tb_regression_inverse;
  localparam logic [15:0] A = 16'd3;
  localparam logic [31:0] B = 32'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regression_inverse_if bus ();

  regression_inverse #(.A(A), .B(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] rem;
    logic        uf;
    logic        of;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] yv);
    exp_t e;
    longint d;
    e.x = '0; e.rem = '0; e.uf = 1'b0; e.of = 1'b0; e.lat = 2;
    d = longint'(yv) - longint'(B);
    if (d < 0) begin
      e.uf = 1'b1;
    end else if (d >= longint'(A) * 65536) begin
      e.of = 1'b1;
      e.x  = 16'hFFFF;
    end else begin
      e.x   = 16'(d / longint'(A));
      e.rem = 16'(d % longint'(A));
      e.lat = 18;
    end
    return e;
  endfunction

  task automatic accept(input logic [31:0] yv);
    int n;
    sb.push_back(model(yv));
    @(negedge clk);
    bus.y = yv;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int stall);
    int lat;
    exp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 100);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lat"}, 64'(lat), 64'(e.lat));
      check({tag, "_x"}, 64'(bus.x), 64'(e.x));
      check({tag, "_rem"}, 64'(bus.rem), 64'(e.rem));
      check({tag, "_uf"}, 64'(bus.underflow), 64'(e.uf));
      check({tag, "_of"}, 64'(bus.overflow), 64'(e.of));
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (i == 3) begin
          bus.y = 32'd40;
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
        check({tag, "_stall_x"}, 64'(bus.x), 64'(e.x));
        check({tag, "_stall_rdy"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_stall_vld"}, 64'(bus.out_valid), 64'd1);
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] yv);
    accept(yv);
    collect(tag, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.y         = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_x", 64'(bus.x), 64'd0);
    check("rst_rem", 64'(bus.rem), 64'd0);
    check("rst_flags", 64'({bus.underflow, bus.overflow}), 64'd0);
    rst = 1'b0;

    run("y7", 32'd7);
    run("y10", 32'd10);
    run("y37", 32'd37);
    run("y772", 32'd772);
    run("y39", 32'd39);
    run("ymax", 32'd196614);
    run("yovf", 32'd196615);
    run("y0", 32'd0);
    run("y6", 32'd6);
    run("yall1", 32'hFFFF_FFFF);

    accept(32'd37);
    collect("bp", 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_no_accept", 64'(bus.in_ready), 64'd1);
      check("bp_no_valid", 64'(bus.out_valid), 64'd0);
    end

    accept(32'd37);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_x", 64'(bus.x), 64'd0);
    check("mid_rst_rem", 64'(bus.rem), 64'd0);
    check("mid_rst_vld", 64'(bus.out_valid), 64'd0);
    check("mid_rst_flags", 64'({bus.underflow, bus.overflow}), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 64'(bus.in_ready), 64'd1);
    check("post_rst_vld", 64'(bus.out_valid), 64'd0);
    run("after_rst", 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
